idma_reg_launch_queue: RTL and testbench

IDMA_REG_LAUNCH_QUEUE -- requirements
Module: idma_reg_launch_queue

---
 rtl/idma_reg_launch_queue.sv | 168 ++++++++++++++++
 tb/tb_idma_reg_launch_queue.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_reg_launch_queue.sv
// Register-frontend launch queue: round-robin arbitration of launch ports into a
// launch FIFO, with per-stream transfer ID issue and completion tracking.
module idma_reg_launch_queue #(
    parameter int unsigned  NumPorts       = 1,
    parameter int unsigned  NumStreams     = 1,
    parameter int unsigned  QueueDepth     = 4,
    parameter int unsigned  IdCounterWidth = 32,
    parameter type          dma_req_t      = logic,
    localparam int unsigned StreamWidth    = (NumStreams > 1) ? $clog2(NumStreams) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic     [NumPorts-1:0]                  launch_valid_i,
    output logic     [NumPorts-1:0]                  launch_ready_o,
    input  dma_req_t [NumPorts-1:0]                  launch_req_i,
    input  logic     [NumPorts-1:0][StreamWidth-1:0] launch_stream_i,
    output logic     [IdCounterWidth-1:0]            launch_id_o,
    output dma_req_t                                 dma_req_o,
    output logic                                     req_valid_o,
    input  logic                                     req_ready_i,
    output logic     [StreamWidth-1:0]               stream_idx_o,
    input  logic     [NumStreams-1:0]                done_i,
    output logic     [NumStreams-1:0][IdCounterWidth-1:0] next_id_o,
    output logic     [NumStreams-1:0][IdCounterWidth-1:0] done_id_o,
    output logic     [NumStreams-1:0]                busy_o,
    output logic                                     full_o
);

    localparam int unsigned PortWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned AddrWidth = $clog2(QueueDepth);

    localparam logic [PortWidth-1:0]      LastPort    = PortWidth'(NumPorts - 1);
    localparam logic [PortWidth-1:0]      PortOne     = PortWidth'(1);
    localparam logic [StreamWidth:0]      StreamLimit = (StreamWidth + 1)'(NumStreams);
    localparam logic [AddrWidth:0]        DepthCount  = (AddrWidth + 1)'(QueueDepth);
    localparam logic [AddrWidth:0]        CountOne    = (AddrWidth + 1)'(1);
    localparam logic [AddrWidth-1:0]      AddrOne     = AddrWidth'(1);
    localparam logic [IdCounterWidth-1:0] IdOne       = IdCounterWidth'(1);

    logic [PortWidth-1:0]   rr_ptr_q;
    logic                   lock_q;
    logic [PortWidth-1:0]   lock_idx_q;
    logic [PortWidth-1:0]   cand;
    logic                   grant_valid;
    logic [PortWidth-1:0]   grant_idx;
    logic [StreamWidth-1:0] raw_stream;
    logic [StreamWidth-1:0] push_stream;
    logic                   pop;
    logic                   can_push;
    logic                   accept;

    dma_req_t               payload_q [QueueDepth];
    logic [StreamWidth-1:0] stream_q  [QueueDepth];
    logic [AddrWidth-1:0]   wr_ptr_q;
    logic [AddrWidth-1:0]   rd_ptr_q;
    logic [AddrWidth:0]     count_q;

    logic [NumStreams-1:0][IdCounterWidth-1:0] issue_q;
    logic [NumStreams-1:0][IdCounterWidth-1:0] done_q;

    // A port that was granted but not yet accepted keeps the grant while it stays valid.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = rr_ptr_q;
        if (lock_q && launch_valid_i[lock_idx_q]) begin
            grant_valid = 1'b1;
            grant_idx   = lock_idx_q;
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                if (!grant_valid && launch_valid_i[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
                cand = (cand == LastPort) ? '0 : cand + PortOne;
            end
        end
    end

    assign raw_stream  = launch_stream_i[grant_idx];
    assign push_stream = ({1'b0, raw_stream} >= StreamLimit) ? '0 : raw_stream;

    assign req_valid_o  = (count_q != '0);
    assign full_o       = (count_q == DepthCount);
    assign dma_req_o    = payload_q[rd_ptr_q];
    assign stream_idx_o = stream_q[rd_ptr_q];

    assign pop      = req_valid_o && req_ready_i;
    assign can_push = !full_o || pop;
    // Gating with rst_ni keeps the handshake quiet for the whole reset window.
    assign accept   = grant_valid && can_push && rst_ni;

    always_comb begin
        launch_ready_o = '0;
        if (accept) begin
            launch_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        for (int c = 0; c < NumStreams; c++) begin
            next_id_o[c] = issue_q[c] + IdOne;
            busy_o[c]    = (issue_q[c] != done_q[c]);
        end
    end

    assign done_id_o   = done_q;
    assign launch_id_o = next_id_o[push_stream];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= (grant_idx == LastPort) ? '0 : grant_idx + PortOne;
            lock_q   <= 1'b0;
        end else begin
            lock_q     <= grant_valid;
            lock_idx_q <= grant_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            payload_q[wr_ptr_q] <= launch_req_i[grant_idx];
            stream_q[wr_ptr_q]  <= push_stream;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + AddrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AddrOne;
            end
            if (accept && !pop) begin
                count_q <= count_q + CountOne;
            end else if (!accept && pop) begin
                count_q <= count_q - CountOne;
            end
        end
    end

    // Completions only count while the stream has something outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_q <= '0;
            done_q  <= '0;
        end else begin
            for (int c = 0; c < NumStreams; c++) begin
                if (accept && (push_stream == StreamWidth'(c))) begin
                    issue_q[c] <= issue_q[c] + IdOne;
                end
                if (done_i[c] && busy_o[c]) begin
                    done_q[c] <= done_q[c] + IdOne;
                end
            end
        end
    end

endmodule

// File: tb/tb_idma_reg_launch_queue.sv
// Bench for idma_reg_launch_queue: 3 ports, 3 streams, depth 4, 4-bit IDs,
// checked against a queue/integer-count reference model.
module tb_idma_reg_launch_queue;

    localparam int NP = 3;
    localparam int NS = 3;
    localparam int QD = 4;
    localparam int IW = 4;

    typedef logic [15:0] payload_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic     [NP-1:0]         launch_valid;
    logic     [NP-1:0]         launch_ready;
    payload_t [NP-1:0]         launch_req;
    logic     [NP-1:0][1:0]    launch_stream;
    logic     [IW-1:0]         launch_id;
    payload_t                  dma_req;
    logic                      req_valid;
    logic                      req_ready;
    logic     [1:0]            stream_idx;
    logic     [NS-1:0]         done;
    logic     [NS-1:0][IW-1:0] next_id;
    logic     [NS-1:0][IW-1:0] done_id;
    logic     [NS-1:0]         busy;
    logic                      full;

    int total = 0;
    int bad   = 0;

    // Reference model: arbitration pointer, held grant, FIFO contents, plain counts.
    int       m_rr;
    int       m_lock;
    int       m_issued [NS];
    int       m_done   [NS];
    payload_t q_pay [$];
    int       q_str [$];

    always #5 clk = ~clk;

    idma_reg_launch_queue #(
        .NumPorts       (NP),
        .NumStreams     (NS),
        .QueueDepth     (QD),
        .IdCounterWidth (IW),
        .dma_req_t      (payload_t)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .launch_valid_i  (launch_valid),
        .launch_ready_o  (launch_ready),
        .launch_req_i    (launch_req),
        .launch_stream_i (launch_stream),
        .launch_id_o     (launch_id),
        .dma_req_o       (dma_req),
        .req_valid_o     (req_valid),
        .req_ready_i     (req_ready),
        .stream_idx_o    (stream_idx),
        .done_i          (done),
        .next_id_o       (next_id),
        .done_id_o       (done_id),
        .busy_o          (busy),
        .full_o          (full)
    );

    function automatic void m_reset();
        m_rr   = 0;
        m_lock = -1;
        for (int c = 0; c < NS; c++) begin
            m_issued[c] = 0;
            m_done[c]   = 0;
        end
        q_pay.delete();
        q_str.delete();
    endfunction

    function automatic int m_grant(logic [NP-1:0] v);
        if (m_lock >= 0 && v[m_lock]) return m_lock;
        for (int i = 0; i < NP; i++) begin
            if (v[(m_rr + i) % NP]) return (m_rr + i) % NP;
        end
        return -1;
    endfunction

    function automatic bit m_accept(logic [NP-1:0] v, logic rdy);
        return (m_grant(v) >= 0) && (q_pay.size() < QD || rdy);
    endfunction

    function automatic int m_map(logic [1:0] s);
        return (int'(s) >= NS) ? 0 : int'(s);
    endfunction

    function automatic logic [IW-1:0] m_next(int c);
        return IW'((m_issued[c] + 1) % (1 << IW));
    endfunction

    // Advance one clock and apply the model's own view of what was accepted/popped.
    task automatic advance();
        int       g;
        bit       acc;
        bit       pop;
        bit       bz [NS];
        payload_t pay;
        int       s;
        g   = m_grant(launch_valid);
        acc = m_accept(launch_valid, req_ready);
        pop = (q_pay.size() > 0) && req_ready;
        for (int c = 0; c < NS; c++) bz[c] = (m_issued[c] != m_done[c]);
        pay = (g >= 0) ? launch_req[g] : '0;
        s   = (g >= 0) ? m_map(launch_stream[g]) : 0;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q_pay.pop_front());
            void'(q_str.pop_front());
        end
        for (int c = 0; c < NS; c++) begin
            if (done[c] && bz[c]) m_done[c]++;
        end
        if (acc) begin
            q_pay.push_back(pay);
            q_str.push_back(s);
            m_issued[s]++;
            m_rr   = (g + 1) % NP;
            m_lock = -1;
        end else begin
            m_lock = g;
        end
    endtask

    task automatic apply_reset();
        launch_valid  = '0;
        launch_req    = '0;
        launch_stream = '0;
        req_ready     = 1'b0;
        done          = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        m_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok           = 1'b0;
        launch_valid = '0;
        req_ready    = 1'b1;
        for (int k = 0; k < 64; k++) begin
            ok = (q_pay.size() == 0);
            for (int c = 0; c < NS; c++) if (m_issued[c] != m_done[c]) ok = 1'b0;
            if (ok) break;
            for (int c = 0; c < NS; c++) done[c] = (m_issued[c] != m_done[c]);
            advance();
        end
        done = '0;
        total++;
        if (!ok || req_valid !== 1'b0 || busy !== '0) begin
            bad++;
            $display("FAIL drain: req_valid=%0b busy=%b, required empty and idle within 64 cycles", req_valid, busy);
        end
    endtask

    task automatic test_reset();
        logic [NS-1:0][IW-1:0] exp_ids;
        for (int c = 0; c < NS; c++) exp_ids[c] = IW'(1);
        rst_n        = 1'b0;
        launch_valid = 3'b001;
        launch_req   = '0;
        launch_stream = '0;
        req_ready    = 1'b1;
        done         = '0;
        #12;
        total++; if (launch_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 000", launch_ready); end
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        total++; if (next_id !== exp_ids) begin bad++; $display("FAIL reset_next_id: got %h want %h", next_id, exp_ids); end
        total++; if (done_id !== '0 || busy !== '0) begin bad++; $display("FAIL reset_done_busy: got done_id=%h busy=%b want 0/0", done_id, busy); end
        launch_valid = '0;
        m_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_launch();
        payload_t p;
        p                = 16'($urandom);
        launch_valid     = 3'b001;
        launch_req[0]    = p;
        launch_stream[0] = 2'd0;
        req_ready        = 1'b1;
        #1;
        total++; if (launch_ready !== 3'b001) begin bad++; $display("FAIL single_ready: got %b want 001", launch_ready); end
        total++; if (launch_id !== 4'd1) begin bad++; $display("FAIL single_launch_id: got %0d want 1", launch_id); end
        advance();
        launch_valid = '0;
        #1;
        total++; if (req_valid !== 1'b1 || dma_req !== p || stream_idx !== 2'd0) begin
            bad++; $display("FAIL single_head: got v=%b req=%h s=%0d want v=1 req=%h s=0", req_valid, dma_req, stream_idx, p);
        end
        total++; if (next_id[0] !== 4'd2 || busy[0] !== 1'b1) begin
            bad++; $display("FAIL single_next_busy: got next=%0d busy=%b want 2/1", next_id[0], busy[0]);
        end
        advance();
        total++; if (req_valid !== 1'b0 || busy[0] !== 1'b1) begin
            bad++; $display("FAIL single_popped: got v=%b busy=%b want 0/1", req_valid, busy[0]);
        end
        done = 3'b001;
        advance();
        done = '0;
        total++; if (done_id[0] !== 4'd1 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL single_done: got done_id=%0d busy=%b want 1/0", done_id[0], busy[0]);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        launch_valid = 3'b111;
        req_ready    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [NP-1:0] want;
            for (int p = 0; p < NP; p++) begin
                launch_req[p]    = 16'($urandom);
                launch_stream[p] = 2'($urandom_range(0, 2));
            end
            want = 3'(1 << (k % 3));
            #1;
            total++; if (launch_ready !== want) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, launch_ready, want); end
            total++; if (launch_id !== m_next(m_map(launch_stream[k % 3]))) begin
                bad++; $display("FAIL rr_id%0d: got %0d want %0d", k, launch_id, m_next(m_map(launch_stream[k % 3])));
            end
            if (k > 0) begin
                total++; if (req_valid !== 1'b1 || dma_req !== q_pay[0]) begin
                    bad++; $display("FAIL rr_head%0d: got v=%b req=%h want v=1 req=%h", k, req_valid, dma_req, q_pay[0]);
                end
            end
            advance();
        end
        drain();
    endtask

    task automatic test_full_backpressure();
        apply_reset();
        req_ready        = 1'b0;
        launch_valid     = 3'b010;
        launch_stream[1] = 2'd2;
        for (int k = 0; k < 5; k++) begin
            logic [NP-1:0] want;
            launch_req[1] = 16'($urandom);
            want = (k < 4) ? 3'b010 : 3'b000;
            #1;
            total++; if (launch_ready !== want) begin bad++; $display("FAIL full_ready%0d: got %b want %b", k, launch_ready, want); end
            if (k == 4) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", full); end
            end
            advance();
        end
        req_ready = 1'b1;
        #1;
        total++; if (launch_ready !== 3'b010 || dma_req !== q_pay[0]) begin
            bad++; $display("FAIL full_push_pop: got ready=%b req=%h want 010 req=%h", launch_ready, dma_req, q_pay[0]);
        end
        advance();
        launch_valid = '0;
        #1;
        total++; if (full !== 1'b1 || dma_req !== q_pay[0]) begin
            bad++; $display("FAIL full_after: got full=%b req=%h want 1 req=%h", full, dma_req, q_pay[0]);
        end
        total++; if (next_id[2] !== 4'd6) begin bad++; $display("FAIL full_next_id: got %0d want 6", next_id[2]); end
        drain();
    endtask

    task automatic test_id_wrap();
        apply_reset();
        launch_valid     = 3'b001;
        launch_stream[0] = 2'd1;
        req_ready        = 1'b1;
        for (int k = 0; k < 16; k++) begin
            launch_req[0] = 16'($urandom);
            done          = (m_issued[1] != m_done[1]) ? 3'b010 : 3'b000;
            #1;
            total++; if (launch_ready !== 3'b001 || launch_id !== m_next(1)) begin
                bad++; $display("FAIL wrap_launch%0d: got ready=%b id=%0d want 001 id=%0d", k, launch_ready, launch_id, m_next(1));
            end
            advance();
        end
        drain();
        total++; if (next_id[1] !== 4'd1 || done_id[1] !== 4'd0 || busy[1] !== 1'b0) begin
            bad++; $display("FAIL wrap_final: got next=%0d done=%0d busy=%b want 1/0/0", next_id[1], done_id[1], busy[1]);
        end
    endtask

    task automatic test_streams_independent();
        apply_reset();
        done = 3'b010;
        advance();
        done = '0;
        total++; if (done_id[1] !== 4'd0 || busy[1] !== 1'b0) begin
            bad++; $display("FAIL indep_spurious_done: got done=%0d busy=%b want 0/0", done_id[1], busy[1]);
        end
        launch_valid = 3'b100;
        req_ready    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            launch_req[2]    = 16'($urandom);
            launch_stream[2] = (k == 0) ? 2'd0 : (k == 1) ? 2'd2 : 2'd3;
            advance();
        end
        launch_valid = '0;
        #1;
        total++; if (next_id[0] !== 4'd3 || next_id[1] !== 4'd1 || next_id[2] !== 4'd2) begin
            bad++; $display("FAIL indep_next_id: got %0d/%0d/%0d want 3/1/2", next_id[0], next_id[1], next_id[2]);
        end
        done = 3'b011;
        advance();
        done = '0;
        total++; if (done_id[0] !== 4'd1 || done_id[1] !== 4'd0 || busy !== 3'b101) begin
            bad++; $display("FAIL indep_done: got done0=%0d done1=%0d busy=%b want 1/0/101", done_id[0], done_id[1], busy);
        end
        drain();
    endtask

    task automatic test_reset_midop();
        logic [NS-1:0][IW-1:0] exp_ids;
        for (int c = 0; c < NS; c++) exp_ids[c] = IW'(1);
        apply_reset();
        req_ready    = 1'b0;
        launch_valid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            launch_req[0]    = 16'($urandom);
            launch_stream[0] = 2'($urandom_range(0, 2));
            advance();
        end
        launch_valid = '0;
        #1;
        total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL midrst_queued: got v=%b want 1", req_valid); end
        #2 rst_n = 1'b0;
        launch_valid = 3'b001;
        #1;
        total++; if (req_valid !== 1'b0 || full !== 1'b0 || launch_ready !== '0) begin
            bad++; $display("FAIL midrst_clear: got v=%b full=%b ready=%b want 0/0/000", req_valid, full, launch_ready);
        end
        total++; if (next_id !== exp_ids || busy !== '0) begin
            bad++; $display("FAIL midrst_ids: got next=%h busy=%b want %h/000", next_id, busy, exp_ids);
        end
        m_reset();
        @(negedge clk);
        launch_valid = '0;
        req_ready    = 1'b1;
        rst_n        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale%0d: got v=%b want 0", k, req_valid); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            int            g;
            bit            acc;
            logic [NP-1:0] want;
            launch_valid = 3'($urandom);
            for (int p = 0; p < NP; p++) begin
                launch_req[p]    = 16'($urandom);
                launch_stream[p] = 2'($urandom_range(0, 3));
            end
            req_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NS; c++) done[c] = ($urandom_range(0, 3) != 0);
            g    = m_grant(launch_valid);
            acc  = m_accept(launch_valid, req_ready);
            want = acc ? 3'(1 << g) : 3'b000;
            #1;
            total++; if (launch_ready !== want) begin bad++; $display("FAIL rand_ready%0d: got %b want %b", k, launch_ready, want); end
            if (acc) begin
                total++; if (launch_id !== m_next(m_map(launch_stream[g]))) begin
                    bad++; $display("FAIL rand_id%0d: got %0d want %0d", k, launch_id, m_next(m_map(launch_stream[g])));
                end
            end
            total++; if (req_valid !== (q_pay.size() > 0) || full !== (q_pay.size() == QD)) begin
                bad++; $display("FAIL rand_occ%0d: got v=%b full=%b want occupancy %0d", k, req_valid, full, q_pay.size());
            end
            if (q_pay.size() > 0) begin
                total++; if (dma_req !== q_pay[0] || stream_idx !== 2'(q_str[0])) begin
                    bad++; $display("FAIL rand_head%0d: got req=%h s=%0d want req=%h s=%0d", k, dma_req, stream_idx, q_pay[0], q_str[0]);
                end
            end
            for (int c = 0; c < NS; c++) begin
                total++;
                if (next_id[c] !== m_next(c) || done_id[c] !== IW'(m_done[c] % (1 << IW)) ||
                    busy[c] !== (m_issued[c] != m_done[c])) begin
                    bad++; $display("FAIL rand_ctr%0d_s%0d: got next=%0d done=%0d busy=%b want %0d/%0d/%b", k, c,
                        next_id[c], done_id[c], busy[c], m_next(c), m_done[c] % (1 << IW), m_issued[c] != m_done[c]);
                end
            end
            advance();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_launch();
        test_round_robin();
        test_full_backpressure();
        test_id_wrap();
        test_streams_independent();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, required completion");
        $fatal(1, "timeout");
    end

endmodule
